// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// The owner code tags the single in-flight RAM access so its read data can be steered back.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles a fetch request has been denied.
// at_limit tells the arbiter that fetch must be let through this cycle.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != LIMIT_C)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt      = cnt_reg;
  assign at_limit = (cnt_reg == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and load/store (D) ports.
// D has priority unless fetch has been starved for STARVE_LIMIT cycles; read data returns one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [CNT_W-1:0]    starve_cnt
);

  localparam int BE_W = DATA_W / 8;

  logic              fetch_force;
  logic              starve_at_limit;
  owner_t            owner_reg;
  owner_t            owner_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (i_gnt | ~i_req),
    .inc      (i_req & ~i_gnt),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

  // Grants are qualified by rst_n so nothing is accepted while reset is held.
  assign fetch_force = i_req & starve_at_limit;
  assign d_gnt       = rst_n & d_req & ~fetch_force;
  assign i_gnt       = rst_n & i_req & (fetch_force | ~d_req);
  assign ram_en      = i_gnt | d_gnt;

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_we
      assign ram_we[gi] = d_gnt & d_we[gi];
    end
  endgenerate

  // Idle cycles replay the last granted address/data so the RAM pins stay quiet.
  always_comb begin
    ram_addr  = addr_hold_reg;
    ram_wdata = wdata_hold_reg;
    if (i_gnt) begin
      ram_addr = i_addr;
    end else if (d_gnt) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (i_gnt) begin
      owner_next = OWN_I;
    end else if (d_gnt) begin
      owner_next = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWN_NONE;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else begin
      owner_reg <= owner_next;
      if (ram_en) begin
        addr_hold_reg <= ram_addr;
      end
      if (d_gnt) begin
        wdata_hold_reg <= d_wdata;
      end
    end
  end

  assign i_rvalid = (owner_reg == OWN_I);
  assign d_rvalid = (owner_reg == OWN_D);
  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bench-side RAM, directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [BW-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_en;
  logic [BW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [3:0]    starve_cnt;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Bench-side RAM: one-cycle registered read, byte-enabled writes.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < BW; b++) begin
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  // Reference model state, transaction level.
  int            m_wait;        // consecutive denied fetch cycles, capped at LIMIT
  logic          m_ig, m_dg;    // grants the model decided for the current cycle
  int            m_own;         // 0 none, 1 fetch, 2 load/store response due this cycle
  logic          m_is_read;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;

  task automatic model_reset();
    m_wait = 0; m_ig = 1'b0; m_dg = 1'b0; m_own = 0; m_is_read = 1'b0;
    m_data = '0; m_last_addr = '0; m_last_wdata = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_grants", {i_gnt, d_gnt}, 2'b00);
      check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
      check("rst_ram_en", {ram_en, ram_we}, '0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_ram_wdata", ram_wdata, '0);
      check("rst_starve", starve_cnt, '0);
      model_reset();
    end else begin
      logic starved;
      starved = i_req && (m_wait >= LIMIT);
      m_dg = d_req && !starved;
      m_ig = i_req && !m_dg;
      check("i_gnt", i_gnt, m_ig);
      check("d_gnt", d_gnt, m_dg);
      check("ram_en", ram_en, m_ig || m_dg);
      check("ram_we", ram_we, m_dg ? d_we : '0);
      check("ram_addr", ram_addr, m_ig ? i_addr : (m_dg ? d_addr : m_last_addr));
      check("ram_wdata", ram_wdata, m_dg ? d_wdata : m_last_wdata);
      check("starve_cnt", starve_cnt, m_wait);
      check("i_rvalid", i_rvalid, m_own == 1);
      check("d_rvalid", d_rvalid, m_own == 2);
      if (m_own == 1) check("i_rdata", i_rdata, m_data);
      if (m_own == 2 && m_is_read) check("d_rdata", d_rdata, m_data);
      if (m_ig || m_dg) $display("[TB] t=%0t %s addr=0x%03h we=%b", $time,
                                  m_ig ? "FETCH" : "LDST", m_ig ? i_addr : d_addr,
                                  m_dg ? d_we : 4'b0);
      // Advance the model to the next cycle.
      m_own = m_ig ? 1 : (m_dg ? 2 : 0);
      m_is_read = m_ig || (m_dg && d_we == '0);
      if (m_ig) begin
        m_data = ref_mem[i_addr];
        m_last_addr = i_addr;
      end else if (m_dg) begin
        m_data = ref_mem[d_addr];
        m_last_addr = d_addr;
        m_last_wdata = d_wdata;
        for (int b = 0; b < BW; b++) begin
          if (d_we[b]) ref_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
        end
      end
      if (m_ig || !i_req) m_wait = 0;
      else if (m_wait < LIMIT) m_wait = m_wait + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    logic [DW-1:0] init_w;
    for (int i = 0; i < DEPTH; i++) begin
      init_w = DW'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
      mem[i] = init_w;
      ref_mem[i] = init_w;
    end
    mem[14'h010] = 32'h0050_0093; ref_mem[14'h010] = 32'h0050_0093;
    mem[14'h3FF] = 32'hDEAD_BEEF; ref_mem[14'h3FF] = 32'hDEAD_BEEF;
    mem[14'h020] = 32'h1122_3344; ref_mem[14'h020] = 32'h1122_3344;
    ram_rdata = '0;

    idle_inputs();
    rst_n = 1'b0;
    #22 rst_n = 1'b1;

    // Fetch only
    step(); i_req = 1'b1; i_addr = 14'h010;
    @(negedge clk); check("fetch_gnt", i_gnt, 1'b1);
    step(); i_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", i_rvalid, 1'b1);
    check("fetch_rdata", i_rdata, 32'h0050_0093);
    check("fetch_no_drvalid", d_rvalid, 1'b0);

    // Load only
    step(); d_req = 1'b1; d_we = '0; d_addr = 14'h3FF;
    @(negedge clk); check("load_gnt", d_gnt, 1'b1);
    step(); d_req = 1'b0;
    @(negedge clk);
    check("load_rvalid", d_rvalid, 1'b1);
    check("load_rdata", d_rdata, 32'hDEAD_BEEF);

    // Byte store then read-back
    step(); d_req = 1'b1; d_we = 4'b0010; d_addr = 14'h020; d_wdata = 32'h0000_AB00;
    @(negedge clk);
    check("store_gnt", d_gnt, 1'b1);
    check("store_ram_we", ram_we, 4'b0010);
    step(); d_we = '0;
    @(negedge clk); check("store_rvalid", d_rvalid, 1'b1);
    step(); d_req = 1'b0;
    @(negedge clk); check("store_readback", d_rdata, 32'h1122_AB44);

    // Starvation: both held for 10 cycles
    step(); i_req = 1'b1; i_addr = 14'h010; d_req = 1'b1; d_addr = 14'h3FF; d_we = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("starve_i_gnt_c%0d", c), i_gnt, (c == 4 || c == 9));
      check($sformatf("starve_d_gnt_c%0d", c), d_gnt, !(c == 4 || c == 9));
      if (c == 4) check("starve_cnt_at_force", starve_cnt, 4'd4);
      if (c == 5) check("starve_cnt_after_force", starve_cnt, 4'd0);
      step();
    end
    idle_inputs();

    // Back-to-back D, I, D
    step(); d_req = 1'b1; d_addr = 14'h3FF; i_req = 1'b1; i_addr = 14'h010;
    @(negedge clk); check("b2b_c0_dgnt", d_gnt, 1'b1);
    step(); d_req = 1'b0;
    @(negedge clk);
    check("b2b_c1_ignt", i_gnt, 1'b1);
    check("b2b_c1_drvalid", d_rvalid, 1'b1);
    check("b2b_c1_drdata", d_rdata, 32'hDEAD_BEEF);
    step(); i_req = 1'b0; d_req = 1'b1; d_addr = 14'h020;
    @(negedge clk);
    check("b2b_c2_dgnt", d_gnt, 1'b1);
    check("b2b_c2_irvalid", i_rvalid, 1'b1);
    check("b2b_c2_irdata", i_rdata, 32'h0050_0093);
    step(); d_req = 1'b0;
    @(negedge clk);
    check("b2b_c3_drvalid", d_rvalid, 1'b1);
    check("b2b_c3_drdata", d_rdata, 32'h1122_AB44);

    // Reset mid-access, with fetch starving so the counter is non-zero
    step(); d_req = 1'b1; d_addr = 14'h3FF; i_req = 1'b1; i_addr = 14'h010;
    @(negedge clk); check("rst_mid_dgnt", d_gnt, 1'b1);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_drvalid", d_rvalid, 1'b0);
    check("rst_mid_starve", starve_cnt, 4'd0);
    check("rst_mid_ram_en", ram_en, 1'b0);
    check("rst_mid_grants", {i_gnt, d_gnt}, 2'b00);
    idle_inputs();
    step();
    #1 rst_n = 1'b1;
    step(); d_req = 1'b1; d_addr = 14'h3FF;
    @(negedge clk); check("reissue_gnt", d_gnt, 1'b1);
    step(); d_req = 1'b0;
    @(negedge clk);
    check("reissue_rvalid", d_rvalid, 1'b1);
    check("reissue_rdata", d_rdata, 32'hDEAD_BEEF);

    // Randomized traffic; a request is only replaced once the model says it was granted.
    step();
    for (int n = 0; n < 3000; n++) begin
      if (!i_req || m_ig) begin
        i_req  = ($urandom_range(0, 99) < 70);
        i_addr = AW'($urandom_range(0, 63));
      end
      if (!d_req || m_dg) begin
        d_req   = ($urandom_range(0, 99) < 65);
        d_addr  = ($urandom_range(0, 7) == 0) ? 14'h3FF : AW'($urandom_range(0, 63));
        d_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : BW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      step();
    end
    idle_inputs();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
